// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: per-channel state codes, also decoded by the display logic.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } sw_state_t;

   localparam logic [1:0] SW_IDLE  = 2'b00;
   localparam logic [1:0] SW_RUN   = 2'b01;
   localparam logic [1:0] SW_PAUSE = 2'b10;
   localparam logic [1:0] SW_LAP   = 2'b11;

endpackage

// File: rtl/sw_chan_fsm.sv
// One stopwatch channel: key edge detect, long-press hold counter and run/lap state machine.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | stopped and cleared, en=0 freeze=0
// ST_RUN   | counting, en=1 freeze=0
// ST_PAUSE | stopped, count kept, en=0 freeze=0
// ST_LAP   | counting with display held, en=1 freeze=1
module sw_chan_fsm
   import stopwatch_pkg::*;
#(
   parameter int HOLD_CYC = 4
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       mode,
   input  logic       key_ss,
   input  logic       key_lap,
   output logic       en,
   output logic       freeze,
   output logic       clr,
   output logic [1:0] state_code
);

   localparam int CW = $clog2(HOLD_CYC + 1);

   sw_state_t     state;
   logic          prev_ss;
   logic          prev_lap;
   logic [CW-1:0] hold_cnt;
   logic          ss_ev;
   logic          lap_ev;
   logic          long_hit;

   assign ss_ev      = key_ss & ~prev_ss;
   assign lap_ev     = key_lap & ~prev_lap;
   assign long_hit   = ~mode & key_lap & (hold_cnt == CW'(HOLD_CYC - 1));
   assign state_code = state;

   // Previous key levels; reset high so a key held through reset release is not an event.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_ss  <= 1'b1;
         prev_lap <= 1'b1;
      end else begin
         prev_ss  <= key_ss;
         prev_lap <= key_lap;
      end
   end

   // Consecutive-high count of the lap key, saturating at the long-press terminal count.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
      end else if (mode || !key_lap) begin
         hold_cnt <= '0;
      end else if (hold_cnt != CW'(HOLD_CYC)) begin
         hold_cnt <= hold_cnt + CW'(1);
      end
   end

   // State machine with registered outputs; long press beats start/stop, which beats lap.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         en     <= 1'b0;
         freeze <= 1'b0;
         clr    <= 1'b0;
      end else begin
         clr <= 1'b0;
         if (!mode) begin
            if (long_hit) begin
               state  <= ST_IDLE;
               en     <= 1'b0;
               freeze <= 1'b0;
               clr    <= ~clr;
            end else if (ss_ev) begin
               case (state)
                  ST_IDLE, ST_PAUSE: begin
                     state  <= ST_RUN;
                     en     <= 1'b1;
                     freeze <= 1'b0;
                  end
                  default: begin
                     state  <= ST_PAUSE;
                     en     <= 1'b0;
                     freeze <= 1'b0;
                  end
               endcase
            end else if (lap_ev) begin
               case (state)
                  ST_RUN: begin
                     state  <= ST_LAP;
                     en     <= 1'b1;
                     freeze <= 1'b1;
                  end
                  ST_LAP: begin
                     state  <= ST_RUN;
                     en     <= 1'b1;
                     freeze <= 1'b0;
                  end
                  ST_PAUSE: begin
                     state  <= ST_IDLE;
                     en     <= 1'b0;
                     freeze <= 1'b0;
                     clr    <= ~clr;
                  end
                  default: begin
                     state  <= ST_IDLE;
                     en     <= 1'b0;
                     freeze <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: rtl/stopwatch_run_ctrl.sv
// Multi-channel stopwatch run controller: one independent sw_chan_fsm per channel.
module stopwatch_run_ctrl
   import stopwatch_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int HOLD_CYC = 50_000_000
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic                  mode,
   input  logic [NUM_CH-1:0]     key_ss,
   input  logic [NUM_CH-1:0]     key_lap,
   output logic [NUM_CH-1:0]     en,
   output logic [NUM_CH-1:0]     freeze,
   output logic [NUM_CH-1:0]     clr,
   output logic [2*NUM_CH-1:0]   state
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sw_chan_fsm #(
         .HOLD_CYC (HOLD_CYC)
      ) u_chan (
         .sys_clk    (sys_clk),
         .rst_n      (rst_n),
         .mode       (mode),
         .key_ss     (key_ss[i]),
         .key_lap    (key_lap[i]),
         .en         (en[i]),
         .freeze     (freeze[i]),
         .clr        (clr[i]),
         .state_code (state[2*i +: 2])
      );
   end

endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// Bench for stopwatch_run_ctrl (NUM_CH=2, HOLD_CYC=4): cycle model plus directed literal checks.
module tb_stopwatch_run_ctrl;

   localparam int NUM_CH = 2;
   localparam int HOLD   = 4;

   logic                sys_clk = 1'b0;
   logic                rst_n   = 1'b0;
   logic                mode    = 1'b0;
   logic [NUM_CH-1:0]   key_ss  = '0;
   logic [NUM_CH-1:0]   key_lap = '0;
   logic [NUM_CH-1:0]   en;
   logic [NUM_CH-1:0]   freeze;
   logic [NUM_CH-1:0]   clr;
   logic [2*NUM_CH-1:0] state;

   int errors = 0;
   int checks = 0;

   stopwatch_run_ctrl #(.NUM_CH(NUM_CH), .HOLD_CYC(HOLD)) dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .mode    (mode),
      .key_ss  (key_ss),
      .key_lap (key_lap),
      .en      (en),
      .freeze  (freeze),
      .clr     (clr),
      .state   (state)
   );

   always #5 sys_clk = ~sys_clk;

   // Behavioural model: state numbers 0=IDLE 1=RUN 2=PAUSE 3=LAP, transitions from lookup tables.
   int ss_next  [4] = '{1, 2, 1, 2};
   int lap_next [4] = '{0, 3, 0, 1};
   int en_of    [4] = '{0, 1, 0, 1};
   int frz_of   [4] = '{0, 0, 0, 1};

   int m_st   [NUM_CH];
   int m_held [NUM_CH];
   bit m_pss  [NUM_CH];
   bit m_plap [NUM_CH];
   bit m_clr  [NUM_CH];

   always @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_st[c] = 0; m_held[c] = 0; m_pss[c] = 1; m_plap[c] = 1; m_clr[c] = 0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            bit ss_e, lap_e, long_e, want_clr;
            ss_e  = key_ss[c] && !m_pss[c];
            lap_e = key_lap[c] && !m_plap[c];
            m_pss[c]  = key_ss[c];
            m_plap[c] = key_lap[c];
            want_clr = 0;
            if (mode) begin
               m_held[c] = 0;
            end else begin
               long_e = key_lap[c] && (m_held[c] + 1 == HOLD);
               m_held[c] = key_lap[c] ? ((m_held[c] < HOLD) ? m_held[c] + 1 : HOLD) : 0;
               if (long_e) begin
                  m_st[c] = 0; want_clr = 1;
               end else if (ss_e) begin
                  m_st[c] = ss_next[m_st[c]];
               end else if (lap_e) begin
                  want_clr = (m_st[c] == 2);
                  m_st[c]  = lap_next[m_st[c]];
               end
            end
            // A clear pulse never lasts two cycles.
            m_clr[c] = want_clr && !m_clr[c];
         end
      end
   end

   // Per-cycle comparison against the model, away from the clock edge.
   always @(posedge sys_clk) begin
      logic [NUM_CH-1:0]   x_en, x_frz, x_clr;
      logic [2*NUM_CH-1:0] x_st;
      #2;
      for (int c = 0; c < NUM_CH; c++) begin
         x_en[c]       = 1'(en_of[m_st[c]]);
         x_frz[c]      = 1'(frz_of[m_st[c]]);
         x_clr[c]      = m_clr[c];
         x_st[2*c +: 2] = 2'(m_st[c]);
      end
      checks += 4;
      if (en !== x_en)     begin errors++; $display("FAIL model_en t=%0t got=%b want=%b", $time, en, x_en); end
      if (freeze !== x_frz) begin errors++; $display("FAIL model_freeze t=%0t got=%b want=%b", $time, freeze, x_frz); end
      if (clr !== x_clr)   begin errors++; $display("FAIL model_clr t=%0t got=%b want=%b", $time, clr, x_clr); end
      if (state !== x_st)  begin errors++; $display("FAIL model_state t=%0t got=%b want=%b", $time, state, x_st); end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic pulse_ss(input int ch);
      key_ss[ch] = 1'b1; cyc(); key_ss[ch] = 1'b0;
   endtask

   task automatic pulse_lap(input int ch);
      key_lap[ch] = 1'b1; cyc(); key_lap[ch] = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_en",     32'(en),     0);
      chk("rst_state",  32'(state),  0);
      chk("rst_clr",    32'(clr),    0);
      cyc(); rst_n = 1'b1; cyc(2);

      // Start, stop, clear on channel 0
      pulse_ss(0);
      chk("ss_idle_run_state", 32'(state[1:0]), 32'h1);
      chk("ss_idle_run_en",    32'(en[0]),      32'h1);
      cyc();
      pulse_ss(0);
      chk("ss_run_pause_state", 32'(state[1:0]), 32'h2);
      chk("ss_run_pause_en",    32'(en[0]),      32'h0);
      cyc();
      pulse_lap(0);
      chk("lap_pause_idle_state", 32'(state[1:0]), 32'h0);
      chk("lap_pause_idle_clr",   32'(clr),        32'h1);
      cyc();
      chk("clr_one_cycle", 32'(clr),       32'h0);
      chk("ch1_untouched", 32'(state[3:2]), 32'h0);

      // Lap toggling, and simultaneous ss+lap on channel 1
      pulse_ss(0); cyc();
      pulse_lap(0);
      chk("lap_state",  32'(state[1:0]), 32'h3);
      chk("lap_freeze", 32'(freeze[0]),  32'h1);
      chk("lap_en",     32'(en[0]),      32'h1);
      cyc();
      pulse_lap(0);
      chk("lap_run_state",  32'(state[1:0]), 32'h1);
      chk("lap_run_freeze", 32'(freeze[0]),  32'h0);
      cyc();
      pulse_ss(1); cyc();
      key_ss[1] = 1'b1; key_lap[1] = 1'b1; cyc();
      key_ss[1] = 1'b0; key_lap[1] = 1'b0;
      chk("ss_wins_state", 32'(state[3:2]), 32'h2);
      chk("ss_wins_clr",   32'(clr),        32'h0);
      cyc();
      pulse_lap(1); cyc();
      chk("ch1_cleared", 32'(state[3:2]), 32'h0);

      // Long press on channel 0 from RUN
      key_lap[0] = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         chk($sformatf("long_state_%0d", i), 32'(state[1:0]), (i < HOLD) ? 32'h3 : 32'h0);
         chk($sformatf("long_clr_%0d", i),   32'(clr[0]),     (i == HOLD) ? 32'h1 : 32'h0);
      end
      key_lap[0] = 1'b0; cyc(2);

      // Other mode: keys ignored, running channel keeps running
      pulse_ss(0); cyc();
      mode = 1'b1; cyc();
      pulse_ss(0); cyc();
      chk("mode1_en",    32'(en[0]),      32'h1);
      chk("mode1_state", 32'(state[1:0]), 32'h1);
      key_lap[0] = 1'b1; cyc(6); key_lap[0] = 1'b0;
      chk("mode1_no_long", 32'(state[1:0]), 32'h1);
      cyc();
      key_ss[0] = 1'b1; cyc();
      mode = 1'b0; cyc(3);
      chk("held_across_mode", 32'(state[1:0]), 32'h1);
      key_ss[0] = 1'b0; cyc();
      pulse_ss(0);
      chk("repress_pause", 32'(state[1:0]), 32'h2);
      cyc();

      // Key held through reset release
      rst_n = 1'b0; key_ss[0] = 1'b1; cyc(2);
      rst_n = 1'b1; cyc(3);
      chk("held_thru_reset", 32'(state[1:0]), 32'h0);
      key_ss[0] = 1'b0; cyc();

      // Asynchronous reset in LAP, mid long-press
      pulse_ss(0); cyc();
      pulse_lap(0); cyc();
      key_lap[0] = 1'b1; cyc(2);
      @(posedge sys_clk); #3;
      rst_n = 1'b0; #1;
      chk("async_rst_en",     32'(en),     0);
      chk("async_rst_freeze", 32'(freeze), 0);
      chk("async_rst_state",  32'(state),  0);
      chk("async_rst_clr",    32'(clr),    0);
      key_lap[0] = 1'b0;
      cyc(2); rst_n = 1'b1; cyc(3);
      chk("after_rst_idle", 32'(state), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_run_ctrl.md
STOPWATCH_RUN_CTRL -- requirements
Module: stopwatch_run_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent stopwatch channels (1..8).
REQ-002 SHALL have parameter HOLD_CYC, default 50_000_000: consecutive high cycles of a lap/clear key that make a long press (>=2).
REQ-003 SHALL have port sys_clk, input, 1: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port mode, input, 1: 0 = timing mode, keys act; 1 = other mode, keys ignored.
REQ-006 SHALL have port key_ss, input, NUM_CH: debounced start/stop key levels, one bit per channel.
REQ-007 SHALL have port key_lap, input, NUM_CH: debounced lap/clear key levels, one bit per channel.
REQ-008 SHALL have port en, output, NUM_CH: counter enable per channel, registered.
REQ-009 SHALL have port freeze, output, NUM_CH: display-hold (lap) per channel, registered.
REQ-010 SHALL have port clr, output, NUM_CH: one-cycle counter-clear pulse per channel, registered.
REQ-011 SHALL have port state, output, 2*NUM_CH: per-channel state code, channel i at bits [2i+1:2i].

Function
REQ-012 Channels SHALL be fully independent; a rule stated for one channel applies to each.
REQ-013 Rising-edge detect per key: event = key high at this edge AND low at previous edge (registered previous level).
REQ-014 States and outputs: IDLE(00) en=0 freeze=0; RUN(01) en=1 freeze=0; PAUSE(10) en=0 freeze=0; LAP(11) en=1 freeze=1.
REQ-015 Transitions on ss event: IDLE->RUN, RUN->PAUSE, PAUSE->RUN, LAP->PAUSE.
REQ-016 Transitions on lap event: RUN->LAP, LAP->RUN, PAUSE->IDLE with clr=1 for that one cycle, IDLE->IDLE no clr.
REQ-017 ss and lap events in the same cycle: ss transition taken, lap event discarded.
REQ-018 Latency: key first sampled high at edge k -> new en/freeze/state/clr visible after edge k; no further delay.
REQ-019 Long press: hold counter counts consecutive edges with key_lap high; on reaching HOLD_CYC, channel SHALL go to IDLE from any state and pulse clr once.
REQ-020 Hold counter SHALL saturate at HOLD_CYC until key_lap low; exactly one clr per press; counter zeroes when key_lap is low.
REQ-021 Short-press event at start of a long press SHALL still act (e.g. RUN->LAP, later ->IDLE).
REQ-022 Long-press clear SHALL take precedence over any ss event in the same cycle.
REQ-023 mode=1: no transitions, no clr, hold counters held at 0; state and en retained (running channel keeps running).
REQ-024 Edge registers SHALL update regardless of mode, so a key held across a mode 1->0 change generates no event.
REQ-025 clr SHALL never be high two consecutive cycles on one channel.

Reset
REQ-026 rst_n low SHALL immediately force all channels IDLE, en=0, freeze=0, clr=0, state=0, hold counters 0.
REQ-027 Previous-level registers SHALL reset to all ones, so a key held through reset release gives no event.
REQ-028 Reset mid-LAP or mid-long-press SHALL abort it; no clr pulse is emitted on reset.

Structure
REQ-029 State encodings (IDLE, RUN, PAUSE, LAP) SHALL be constants in shared package stopwatch_pkg, used by display logic.
REQ-030 Per-channel logic SHALL be sub-module sw_chan_fsm (edge detect, hold counter of width clog2(HOLD_CYC+1), FSM), instantiated NUM_CH times by generate.

Verification (NUM_CH=2, HOLD_CYC=4)
REQ-031 ss0 pulse, ss0 pulse, lap0 pulse -> ch0 IDLE->RUN(en=1)->PAUSE(en=0)->IDLE, clr[0]=1 exactly one cycle; ch1 stays IDLE.
REQ-032 From RUN, lap0 pulse, lap0 pulse -> LAP (en=1, freeze=1) then RUN (freeze=0); ss1 and lap1 high same cycle in RUN -> ch1 PAUSE, no clr.
REQ-033 ch0 RUN, key_lap[0] held 10 cycles -> LAP on first edge, IDLE with single clr on 4th high edge, no further clr.
REQ-034 ch0 RUN, mode=1, ss0 pulses -> en[0] stays 1; key_ss[0] held high while mode goes 0 -> no event until released and re-pressed.
REQ-035 key_ss[0] high during and after rst_n release -> ch0 stays IDLE; rst_n asserted in LAP -> all outputs 0 immediately, asynchronously.
